// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: holds PC, fetches {PC,2'b00} over req/ack,
// and hands the word to decode with valid/ready. Loads NPC on acceptance.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] NPC,
    output logic [29:0] PC,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        halt,
    output logic        bus_err,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_HOLD,
        S_HALTED,
        S_ERR
    } state_t;

    localparam logic [29:0] PC_RST   = RESET_PC[31:2];
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= PC_RST;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_BOOT: begin
                req_d   = 1'b1;
                tmo_d   = '0;
                state_d = S_REQ;
            end
            S_REQ: begin
                // An ack on the expiry cycle still wins over the timeout.
                if (im_ack) begin
                    instr_d = im_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = S_HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    valid_d = 1'b0;
                    if (halt) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_d    = NPC;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_HALTED: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            S_ERR: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                state_d = S_BOOT;
            end
        endcase
    end

    assign PC          = pc_q;
    assign im_addr     = {pc_q, 2'b00};
    assign im_req      = req_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign bus_err     = err_q;
    assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: main instance with TIMEOUT=16 and a second
// instance with TIMEOUT=4 for the bus-error paths.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] NPC = '0;
    logic [29:0] PC;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack = 1'b0;
    logic [31:0] im_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halt = 1'b0;
    logic        bus_err;
    logic [31:0] fetch_cnt;

    logic [29:0] npc4 = '0;
    logic [29:0] pc4;
    logic        req4;
    logic [31:0] addr4;
    logic        ack4 = 1'b0;
    logic [31:0] rdata4 = '0;
    logic [31:0] instr4;
    logic        valid4;
    logic        ready4 = 1'b0;
    logic        halt4 = 1'b0;
    logic        err4;
    logic [31:0] cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .NPC(NPC), .PC(PC), .im_req(im_req),
        .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .halt(halt), .bus_err(bus_err), .fetch_cnt(fetch_cnt)
    );

    ifu_fetch #(.RESET_PC(32'h0000_3000), .TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .NPC(npc4), .PC(pc4), .im_req(req4),
        .im_addr(addr4), .im_ack(ack4), .im_rdata(rdata4),
        .instr(instr4), .instr_valid(valid4), .instr_ready(ready4),
        .halt(halt4), .bus_err(err4), .fetch_cnt(cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        im_ack = 1'b0; instr_ready = 1'b0; halt = 1'b0; NPC = '0; im_rdata = '0;
        ack4 = 1'b0; ready4 = 1'b0; halt4 = 1'b0; npc4 = '0; rdata4 = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (im_addr !== 32'h0000_3000 || PC !== 30'h0C00) begin
            errors++; $display("FAIL reset_pc: im_addr=%h PC=%h, expected 00003000/0c00", im_addr, PC);
        end
        checks++;
        if (im_req !== 1'b0 || instr_valid !== 1'b0 || bus_err !== 1'b0 || fetch_cnt !== 32'd0 || instr !== 32'd0) begin
            errors++; $display("FAIL reset_outs: req=%b valid=%b err=%b cnt=%0d instr=%h, expected all 0",
                               im_req, instr_valid, bus_err, fetch_cnt, instr);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h0000_3000; exp_addr[1] = 32'h0000_3004; exp_addr[2] = 32'h0000_3008;
        do_reset();
        im_ack = 1'b1;
        instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (im_req !== 1'b1 || instr_valid !== 1'b0 || im_addr !== exp_addr[i]) begin
                errors++; $display("FAIL zw_req%0d: req=%b valid=%b addr=%h, expected 1/0/%h",
                                   i, im_req, instr_valid, im_addr, exp_addr[i]);
            end
            im_rdata = 32'hA000_0000 + 32'(i);
            NPC = 30'h0C01 + 30'(i);
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'hA000_0000 + 32'(i) || im_req !== 1'b0) begin
                errors++; $display("FAIL zw_hold%0d: valid=%b instr=%h req=%b, expected 1/%h/0",
                                   i, instr_valid, instr, im_req, 32'hA000_0000 + 32'(i));
            end
            tick();
        end
        checks++;
        if (fetch_cnt !== 32'd3 || im_addr !== 32'h0000_300C) begin
            errors++; $display("FAIL zw_cnt: fetch_cnt=%0d addr=%h, expected 3/0000300c", fetch_cnt, im_addr);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (im_req !== 1'b1 || im_addr !== 32'h0000_3000 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL ws_stable%0d: req=%b addr=%h valid=%b, expected 1/00003000/0",
                                   i, im_req, im_addr, instr_valid);
            end
            tick();
        end
        im_ack = 1'b1;
        im_rdata = 32'h3C01_0001;
        tick();
        im_ack = 1'b0;
        checks++;
        if (instr !== 32'h3C01_0001 || instr_valid !== 1'b1 || bus_err !== 1'b0 || im_req !== 1'b0) begin
            errors++; $display("FAIL ws_capture: instr=%h valid=%b err=%b req=%b, expected 3c010001/1/0/0",
                               instr, instr_valid, bus_err, im_req);
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (err4 !== 1'b0 || req4 !== 1'b1) begin
                errors++; $display("FAIL to_pending%0d: err=%b req=%b, expected 0/1", i, err4, req4);
            end
            tick();
        end
        checks++;
        if (err4 !== 1'b1 || req4 !== 1'b0) begin
            errors++; $display("FAIL to_expire: err=%b req=%b, expected 1/0", err4, req4);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            ack4 = i[0];
            ready4 = 1'b1;
            tick();
            if (err4 !== 1'b1 || req4 !== 1'b0 || valid4 !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL to_sticky: %0d cycles left ERR, expected 0", bad);
        end
    endtask

    task automatic test_timeout_ack_wins();
        do_reset();
        tick();
        tick(); tick(); tick();
        ack4 = 1'b1;
        rdata4 = 32'h1234_5678;
        tick();
        ack4 = 1'b0;
        checks++;
        if (err4 !== 1'b0 || valid4 !== 1'b1 || instr4 !== 32'h1234_5678) begin
            errors++; $display("FAIL to_ackwins: err=%b valid=%b instr=%h, expected 0/1/12345678",
                               err4, valid4, instr4);
        end
    endtask

    task automatic test_stall_jump();
        int bad;
        do_reset();
        im_ack = 1'b1;
        im_rdata = 32'h0800_0C00;
        tick();
        tick();
        im_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            NPC = i[0] ? 30'h2AAA_AAAA : 30'h1555_5555;
            im_ack = i[0];
            im_rdata = 32'hDEAD_BEEF;
            tick();
            if (instr_valid !== 1'b1 || instr !== 32'h0800_0C00 || im_addr !== 32'h0000_3000 || im_req !== 1'b0) bad++;
        end
        im_ack = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL stall_hold: %0d unstable cycles, expected 0", bad);
        end
        NPC = 30'h0C00;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        NPC = 30'h1555_5555;
        checks++;
        if (PC !== 30'h0C00 || im_addr !== 32'h0000_3000 || im_req !== 1'b1 || fetch_cnt !== 32'd1) begin
            errors++; $display("FAIL stall_jump: PC=%h addr=%h req=%b cnt=%0d, expected 0c00/00003000/1/1",
                               PC, im_addr, im_req, fetch_cnt);
        end
        im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        NPC = 30'h3FFF_FFFF;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (PC !== 30'h3FFF_FFFF || im_addr !== 32'hFFFF_FFFC || fetch_cnt !== 32'd2) begin
            errors++; $display("FAIL top_addr: PC=%h addr=%h cnt=%0d, expected 3fffffff/fffffffc/2",
                               PC, im_addr, fetch_cnt);
        end
    endtask

    task automatic test_halt();
        int bad;
        do_reset();
        im_ack = 1'b1;
        tick();
        tick();
        im_ack = 1'b0;
        halt = 1'b1;
        instr_ready = 1'b1;
        NPC = 30'h1111;
        tick();
        halt = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || im_req !== 1'b0 || fetch_cnt !== 32'd1 || PC !== 30'h0C00) begin
            errors++; $display("FAIL halt_enter: valid=%b req=%b cnt=%0d PC=%h, expected 0/0/1/0c00",
                               instr_valid, im_req, fetch_cnt, PC);
        end
        bad = 0;
        im_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (im_req !== 1'b0 || instr_valid !== 1'b0 || fetch_cnt !== 32'd1 || PC !== 30'h0C00) bad++;
        end
        im_ack = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL halt_stay: %0d cycles left HALTED, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        im_ack = 1'b1;
        instr_ready = 1'b1;
        NPC = 30'h0D00;
        tick();
        tick();
        tick();
        im_ack = 1'b0;
        instr_ready = 1'b0;
        tick();
        checks++;
        if (im_req !== 1'b1 || im_addr !== 32'h0000_3400 || fetch_cnt !== 32'd1) begin
            errors++; $display("FAIL mid_pre: req=%b addr=%h cnt=%0d, expected 1/00003400/1", im_req, im_addr, fetch_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (im_req !== 1'b0 || fetch_cnt !== 32'd0 || PC !== 30'h0C00) begin
            errors++; $display("FAIL mid_async: req=%b cnt=%0d PC=%h, expected 0/0/0c00", im_req, fetch_cnt, PC);
        end
        tick();
        rst_n = 1'b1;
        im_ack = 1'b1;
        im_rdata = 32'h5555_AAAA;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h0000_3000 || fetch_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_boot_ack: valid=%b req=%b addr=%h cnt=%0d, expected 0/1/00003000/0",
                               instr_valid, im_req, im_addr, fetch_cnt);
        end
        tick();
        im_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h5555_AAAA) begin
            errors++; $display("FAIL mid_refetch: valid=%b instr=%h, expected 1/5555aaaa", instr_valid, instr);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_timeout_ack_wins();
        test_stall_jump();
        test_halt();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch front end of the multi-cycle MIPS core; the consumer side of the next-PC unit.
- Holds the architectural PC, drives it to the next-PC unit, and fetches the word at {PC,2'b00} over a req/ack instruction-memory handshake.
- Presents the instruction to decode with a valid/ready handshake.
- When decode accepts an instruction, loads NPC (computed from that instruction) into PC and starts the next fetch.

Parameters:
- RESET_PC, 32'h0000_3000, byte address of the first fetch; bits [1:0] are ignored.
- TIMEOUT, 16, number of REQ cycles without im_ack before a bus error is declared; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- NPC  input  30  next word address from the next-PC unit; valid while instr_valid=1
- PC  output  30  word address of the current instruction; feeds the next-PC unit
- im_req  output  1  instruction-memory request
- im_addr  output  32  byte address, equal to {PC,2'b00}
- im_ack  input  1  memory acknowledge; im_rdata is valid in the same cycle
- im_rdata  input  32  fetched instruction word
- instr  output  32  instruction held for decode
- instr_valid  output  1  instr is valid
- instr_ready  input  1  decode consumes instr this cycle
- halt  input  1  sampled together with acceptance; stops fetching after the current instruction
- bus_err  output  1  sticky fetch-timeout flag
- fetch_cnt  output  32  count of instructions accepted by decode

Behaviour:
- Reset (rst_n=0, asynchronous):
  - PC=RESET_PC[31:2], instr=0, instr_valid=0, im_req=0, bus_err=0, fetch_cnt=0, timeout counter=0, state=BOOT.
- All outputs are registered, except im_addr, which is combinational {PC,2'b00}.
- States: BOOT, REQ, HOLD, HALTED, ERR.
- BOOT: one cycle after reset release -> REQ; im_req=1 from that edge.
- REQ:
  - im_req=1; PC and im_addr stay stable until ack.
  - im_ack=1 -> instr<=im_rdata, instr_valid<=1, im_req<=0, timeout counter cleared, -> HOLD.
  - Zero-wait ack (ack in the first REQ cycle) is legal.
  - No ack -> timeout counter +1. When the counter reaches TIMEOUT-1 with no ack in that cycle: bus_err<=1, im_req<=0, -> ERR.
  - An ack in the same cycle as timeout expiry wins; no error is raised.
- HOLD:
  - instr_valid=1; instr and PC stay stable while instr_ready=0, with no limit on the stall.
  - On instr_ready=1: fetch_cnt+1 (wraps 32'hFFFF_FFFF -> 0) and instr_valid<=0.
    - halt=0: PC<=NPC, im_req<=1, -> REQ.
    - halt=1: PC unchanged, -> HALTED.
- HALTED: im_req=0, instr_valid=0; exits only by reset.
- ERR: im_req=0, instr_valid=0, bus_err=1; exits only by reset.
- im_ack outside REQ is ignored, with no state change.
- NPC is sampled only on the HOLD & instr_ready edge; NPC changes at any other time have no effect.
- PC arithmetic is 30-bit; the block never increments PC itself, so all wrap behaviour comes from NPC.
- Throughput: at most one instruction every 2 cycles (REQ+ack, then HOLD+ready).
- Reset asserted mid-REQ or mid-HOLD:
  - All state is cleared immediately; an outstanding memory request is abandoned.
  - A late im_ack after reset release is ignored unless it arrives in REQ.

Test Plan:
- Reset, release, zero-wait memory (im_ack held 1), instr_ready=1, NPC=PC+1 -> im_addr sequence 0x3000, 0x3004, 0x3008; instr_valid high every 2nd cycle; fetch_cnt=3 after 3 accepts.
- Memory acks after 5 cycles, TIMEOUT=16 -> im_req and im_addr stable for 5 cycles; instr=im_rdata (e.g. 0x3C010001) captured; bus_err=0.
- No im_ack, TIMEOUT=4 -> bus_err=1 exactly 4 REQ cycles after the request starts; im_req=0; stays in ERR through 100 cycles.
- HOLD with instr_ready=0 for 10 cycles while NPC toggles, then ready with NPC=0x0C00 (jump target) -> PC=0x0C00, im_addr=0x3000 on the next request.
- Accept with halt=1 -> HALTED; im_req stays 0; fetch_cnt incremented by 1; PC unchanged.
- Assert rst_n=0 mid-REQ with im_ack arriving one cycle after release -> ack ignored in BOOT; fresh fetch of 0x3000; fetch_cnt=0.
